// File: rtl/gradient_pkg.sv
// gradient_pkg
//   Shared definitions for the batch gradient datapath: sequencer FSM state
//   encoding and the line/lane geometry constants also used by the
//   gradient calculator.
//   No ports (package).
package gradient_pkg;

    localparam int unsigned FLOAT_SIZE    = 32;
    localparam int unsigned DATALINE_SIZE = 16;
    localparam int unsigned DATA_WIDTH    = FLOAT_SIZE * DATALINE_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/gradient_credit_counter.sv
// gradient_credit_counter
//   Tracks batches in flight (last line sent, gradient not yet returned).
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clr             clear count at start of a job (flag is kept)
//     inc             a batch's last line was accepted
//     dec             a gradient result returned
//     inflight        current in-flight count
//     full            inflight has reached MAX_INFLIGHT
//     err_underflow   sticky: dec seen with nothing in flight (cleared by rst)
module gradient_credit_counter #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    input  logic                    dec,
    output logic [CREDIT_WIDTH-1:0] inflight,
    output logic                    full,
    output logic                    err_underflow
);

    logic [CREDIT_WIDTH-1:0] inflight_q, inflight_d;
    logic                    err_q, err_d;

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (clr) begin
            inflight_d = '0;
        end else if (inc && !dec) begin
            inflight_d = inflight_q + CREDIT_WIDTH'(1);
        end else if (dec && !inc) begin
            // Saturate at zero; a stray result only raises the flag.
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - CREDIT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign full          = (inflight_q >= CREDIT_WIDTH'(MAX_INFLIGHT));
    assign err_underflow = err_q;

endmodule

// File: rtl/gradient_batch_sequencer.sv
// gradient_batch_sequencer
//   Frames the rx AXIS stream into batches of N lines for the batch gradient
//   calculator, flags the last line of each batch with TLAST, limits batches
//   in flight to MAX_INFLIGHT, runs cfg_num_batches batches, drains, then
//   pulses done.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     cfg_N, cfg_num_batches      job config, taken on cfg_valid in IDLE
//     cfg_valid / cfg_ready       config handshake (ready only in IDLE)
//     s_axis_rx_data_*            rx line stream in
//     m_axis_grad_*               registered line stream to calculator
//     m_N                         N latched for the job
//     result_TVALID               one pulse per returned batch gradient
//     busy, done                  job status; done pulses on DRAIN->IDLE
//     batches_sent                batches whose TLAST has been issued
//     err_underflow               sticky: result with nothing in flight
module gradient_batch_sequencer #(
    parameter int unsigned DATA_WIDTH   = gradient_pkg::DATA_WIDTH,
    parameter int unsigned N_WIDTH      = 32,
    parameter int unsigned BATCH_WIDTH  = 16,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CREDIT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_WIDTH-1:0]     cfg_N,
    input  logic [BATCH_WIDTH-1:0] cfg_num_batches,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DATA_WIDTH-1:0]  s_axis_rx_data_TDATA,
    input  logic                   s_axis_rx_data_TVALID,
    output logic                   s_axis_rx_data_TREADY,
    output logic [DATA_WIDTH-1:0]  m_axis_grad_TDATA,
    output logic                   m_axis_grad_TVALID,
    output logic                   m_axis_grad_TLAST,
    output logic [N_WIDTH-1:0]     m_N,
    input  logic                   result_TVALID,
    output logic                   busy,
    output logic                   done,
    output logic [BATCH_WIDTH-1:0] batches_sent,
    output logic                   err_underflow
);

    import gradient_pkg::*;

    seq_state_e               state_q, state_d;
    logic [N_WIDTH-1:0]       n_q, n_d;
    logic [N_WIDTH-1:0]       line_cnt_q, line_cnt_d;
    logic [BATCH_WIDTH-1:0]   num_batches_q, num_batches_d;
    logic [BATCH_WIDTH-1:0]   batches_sent_q, batches_sent_d;
    logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic                     done_q, done_d;

    logic [CREDIT_WIDTH-1:0]  inflight;
    logic                     credit_full;
    logic                     cfg_start;
    logic                     accept;
    logic                     last_line;
    logic                     batch_close;
    logic                     final_batch;
    logic                     drain_exit;

    assign cfg_start   = (state_q == ST_IDLE) && cfg_valid &&
                         (cfg_N != '0) && (cfg_num_batches != '0);
    assign accept      = s_axis_rx_data_TVALID && s_axis_rx_data_TREADY;
    assign last_line   = (line_cnt_q == (n_q - N_WIDTH'(1)));
    assign batch_close = accept && last_line;
    assign final_batch = (batches_sent_q == (num_batches_q - BATCH_WIDTH'(1)));
    // Leave DRAIN on the same cycle the final result brings the count to zero.
    assign drain_exit  = (inflight == '0) ||
                         ((inflight == CREDIT_WIDTH'(1)) && result_TVALID);

    gradient_credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .clr           (cfg_start),
        .inc           (batch_close),
        .dec           (result_TVALID),
        .inflight      (inflight),
        .full          (credit_full),
        .err_underflow (err_underflow)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cfg_start)                  state_d = ST_STREAM;
            ST_STREAM: if (batch_close && final_batch) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_exit)                 state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs (registers only, never from TVALID)
    always_comb begin
        cfg_ready             = (state_q == ST_IDLE);
        busy                  = (state_q != ST_IDLE);
        s_axis_rx_data_TREADY = (state_q == ST_STREAM) && !credit_full;
    end

    // Datapath: job config, line counter, output register
    always_comb begin
        n_d            = n_q;
        num_batches_d  = num_batches_q;
        line_cnt_d     = line_cnt_q;
        batches_sent_d = batches_sent_q;
        tdata_d        = tdata_q;
        tvalid_d       = accept;
        tlast_d        = batch_close;
        done_d         = (state_q == ST_DRAIN) && drain_exit;

        if (cfg_start) begin
            n_d            = cfg_N;
            num_batches_d  = cfg_num_batches;
            line_cnt_d     = '0;
            batches_sent_d = '0;
        end
        if (accept) begin
            tdata_d    = s_axis_rx_data_TDATA;
            line_cnt_d = last_line ? '0 : line_cnt_q + N_WIDTH'(1);
        end
        if (batch_close) begin
            batches_sent_d = batches_sent_q + BATCH_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q            <= '0;
            num_batches_q  <= '0;
            line_cnt_q     <= '0;
            batches_sent_q <= '0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            n_q            <= n_d;
            num_batches_q  <= num_batches_d;
            line_cnt_q     <= line_cnt_d;
            batches_sent_q <= batches_sent_d;
            tdata_q        <= tdata_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            done_q         <= done_d;
        end
    end

    assign m_axis_grad_TDATA  = tdata_q;
    assign m_axis_grad_TVALID = tvalid_q;
    assign m_axis_grad_TLAST  = tlast_q;
    assign m_N                = n_q;
    assign done               = done_q;
    assign batches_sent       = batches_sent_q;

endmodule

// File: tb/tb_gradient_batch_sequencer.sv
// tb_gradient_batch_sequencer
//   Randomized and directed stimulus for gradient_batch_sequencer, checked
//   cycle by cycle against a job-level reference model (lines accepted,
//   batches outstanding, job active) kept in the bench.
module tb_gradient_batch_sequencer;

    localparam int unsigned DW   = 512;
    localparam int unsigned NW   = 32;
    localparam int unsigned BW   = 16;
    localparam int unsigned MAXF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] cfg_N;
    logic [BW-1:0] cfg_num_batches;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] s_axis_rx_data_TDATA;
    logic          s_axis_rx_data_TVALID;
    logic          s_axis_rx_data_TREADY;
    logic [DW-1:0] m_axis_grad_TDATA;
    logic          m_axis_grad_TVALID;
    logic          m_axis_grad_TLAST;
    logic [NW-1:0] m_N;
    logic          result_TVALID;
    logic          busy;
    logic          done;
    logic [BW-1:0] batches_sent;
    logic          err_underflow;

    gradient_batch_sequencer #(
        .DATA_WIDTH   (DW),
        .N_WIDTH      (NW),
        .BATCH_WIDTH  (BW),
        .MAX_INFLIGHT (MAXF),
        .CREDIT_WIDTH (3)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_N                 (cfg_N),
        .cfg_num_batches       (cfg_num_batches),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .s_axis_rx_data_TDATA  (s_axis_rx_data_TDATA),
        .s_axis_rx_data_TVALID (s_axis_rx_data_TVALID),
        .s_axis_rx_data_TREADY (s_axis_rx_data_TREADY),
        .m_axis_grad_TDATA     (m_axis_grad_TDATA),
        .m_axis_grad_TVALID    (m_axis_grad_TVALID),
        .m_axis_grad_TLAST     (m_axis_grad_TLAST),
        .m_N                   (m_N),
        .result_TVALID         (result_TVALID),
        .busy                  (busy),
        .done                  (done),
        .batches_sent          (batches_sent),
        .err_underflow         (err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: job-level view
    bit            m_active;
    int unsigned   m_n, m_b, m_lines, m_out;
    bit            m_err;
    bit            e_tvalid, e_tlast, e_done;
    logic [DW-1:0] e_tdata;
    logic [NW-1:0] e_mn;
    longint        cyc = 0;
    longint        due_q[$];
    int unsigned   res_lo = 20, res_hi = 20;

    // Observed DUT activity since clear_obs
    int obs_lines, obs_lasts, obs_done, res_issued, max_out;

    task automatic model_reset();
        m_active = 0; m_n = 0; m_b = 0; m_lines = 0; m_out = 0; m_err = 0;
        e_tvalid = 0; e_tlast = 0; e_done = 0; e_tdata = '0; e_mn = '0;
        due_q.delete();
    endtask

    task automatic clear_obs();
        obs_lines = 0; obs_lasts = 0; obs_done = 0; res_issued = 0; max_out = 0;
    endtask

    function automatic bit pop_due();
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input bit tv, input bit res, input bit cv,
                        input logic [NW-1:0] cn, input logic [BW-1:0] cb);
        logic [DW-1:0] d;
        bit            exp_rdy, acc, last, was_active;
        int unsigned   sent;
        @(negedge clk);
        sent = (m_n != 0) ? m_lines / m_n : 0;
        check("tvalid", m_axis_grad_TVALID, e_tvalid);
        check("tlast", m_axis_grad_TLAST, e_tlast);
        check("tdata", m_axis_grad_TDATA, e_tdata);
        check("done", done, e_done);
        check("busy", busy, m_active);
        check("m_N", m_N, e_mn);
        check("batches_sent", batches_sent, sent);
        check("err_underflow", err_underflow, m_err);
        if (m_axis_grad_TVALID === 1'b1) obs_lines++;
        if (m_axis_grad_TLAST === 1'b1) obs_lasts++;
        if (done === 1'b1) obs_done++;
        if (obs_lasts - res_issued > max_out) max_out = obs_lasts - res_issued;

        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom();
        s_axis_rx_data_TVALID = tv;
        s_axis_rx_data_TDATA  = d;
        result_TVALID         = res;
        cfg_valid             = cv;
        cfg_N                 = cn;
        cfg_num_batches       = cb;
        #1;
        exp_rdy = m_active && (m_lines < m_n * m_b) && (m_out < MAXF);
        check("tready", s_axis_rx_data_TREADY, exp_rdy);
        check("cfg_ready", cfg_ready, !m_active);

        acc        = tv && exp_rdy;
        last       = acc && ((m_lines + 1) % m_n == 0);
        was_active = m_active;
        e_tvalid   = acc;
        e_tlast    = last;
        e_done     = 0;
        if (acc) e_tdata = d;
        if (res) res_issued++;
        if (res && !last && m_out == 0) m_err = 1;
        else m_out = m_out + int'(last) - int'(res);
        if (last) due_q.push_back(cyc + $urandom_range(res_hi, res_lo));
        if (m_active && m_lines == m_n * m_b && m_out == 0) begin
            e_done   = 1;
            m_active = 0;
        end
        m_lines += int'(acc);
        if (!was_active && cv && cn != 0 && cb != 0) begin
            m_active = 1; m_n = cn; m_b = cb; m_lines = 0; m_out = 0; e_mn = cn;
        end
        cyc++;
    endtask

    task automatic idle_step();
        step(0, 0, 0, '0, '0);
    endtask

    task automatic run_until_idle(input int unsigned prob, input int unsigned budget);
        for (int unsigned i = 0; i < budget && m_active; i++)
            step($urandom_range(99) < prob, pop_due(), 0, '0, '0);
        check("job_timeout", m_active, 0);
        idle_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; s_axis_rx_data_TVALID = 0; result_TVALID = 0; cfg_valid = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1; cfg_valid = 0; cfg_N = '0; cfg_num_batches = '0;
        s_axis_rx_data_TVALID = 0; s_axis_rx_data_TDATA = '0; result_TVALID = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        clear_obs();
        idle_step();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_tready", s_axis_rx_data_TREADY, 0);

        // 1: N=4, 2 batches, results 20 cycles after each TLAST
        clear_obs(); res_lo = 20; res_hi = 20;
        step(0, 0, 1, 4, 2);
        run_until_idle(100, 500);
        check("t1_lines", obs_lines, 8);
        check("t1_lasts", obs_lasts, 2);
        check("t1_done", obs_done, 1);
        check("t1_sent", batches_sent, 2);

        // 2: N=1, 6 batches, no results until the credit limit stalls input
        clear_obs(); res_lo = 3; res_hi = 3;
        step(0, 0, 1, 1, 6);
        repeat (10) step(1, 0, 0, '0, '0);
        check("t2_lines", obs_lines, 4);
        check("t2_tready", s_axis_rx_data_TREADY, 0);
        void'(due_q.pop_front());
        step(1, 1, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        idle_step();
        check("t2_fifth", obs_lines, 5);
        run_until_idle(100, 500);
        check("t2_lasts", obs_lasts, 6);

        // 3: last-line accept and result in the same cycle with 2 in flight
        clear_obs(); res_lo = 60; res_hi = 60;
        step(0, 0, 1, 2, 4);
        repeat (5) step(1, 0, 0, '0, '0);
        void'(due_q.pop_front());
        step(1, 1, 0, '0, '0);
        idle_step();
        check("t3_tready", s_axis_rx_data_TREADY, 1);
        run_until_idle(100, 500);
        check("t3_lasts", obs_lasts, 4);

        // 4: zero-field configs ignored; stray result sets sticky flag
        step(0, 0, 1, 0, 5);
        step(0, 0, 1, 3, 0);
        idle_step();
        check("t4_busy", busy, 0);
        check("t4_cfg_ready", cfg_ready, 1);
        check("t4_m_N", m_N, 2);
        step(0, 1, 0, '0, '0);
        idle_step();
        check("t4_err", err_underflow, 1);
        repeat (3) idle_step();
        check("t4_err_sticky", err_underflow, 1);

        // 5: reset mid-batch, then a fresh N=3 job
        res_lo = 10; res_hi = 10;
        step(0, 0, 1, 4, 2);
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        do_reset();
        check("t5_tready", s_axis_rx_data_TREADY, 0);
        check("t5_tvalid", m_axis_grad_TVALID, 0);
        check("t5_sent", batches_sent, 0);
        check("t5_busy", busy, 0);
        check("t5_err", err_underflow, 0);
        clear_obs();
        step(0, 0, 1, 3, 1);
        run_until_idle(100, 300);
        check("t5_lines", obs_lines, 3);
        check("t5_lasts", obs_lasts, 1);

        // 6: random gaps and result delays, N=5, 3 batches, then random jobs
        clear_obs(); res_lo = 5; res_hi = 40;
        step(0, 0, 1, 5, 3);
        run_until_idle(50, 3000);
        check("t6_lines", obs_lines, 15);
        check("t6_lasts", obs_lasts, 3);
        check("t6_max_inflight", max_out <= int'(MAXF), 1);
        for (int j = 0; j < 4; j++) begin
            int unsigned rn, rb;
            rn = $urandom_range(6, 1);
            rb = $urandom_range(5, 1);
            clear_obs();
            step(0, 0, 1, NW'(rn), BW'(rb));
            run_until_idle(60, 3000);
            check("rand_lines", obs_lines, rn * rb);
            check("rand_max_inflight", max_out <= int'(MAXF), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
